// File: rtl/tdm_mux_8x1.sv
// 8-channel time-division multiplexer: captures 8 parallel bits on start
// and emits them serially, one channel per clock, with the index on S.
module tdm_mux_8x1 #(
   parameter bit MSB_FIRST = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] D,
   input  logic       start,
   output logic       Y,
   output logic [2:0] S,
   output logic       valid,
   output logic       last,
   output logic       busy
);

   typedef enum logic {
      IDLE,
      SEND
   } state_t;

   localparam logic [2:0] FIRST = MSB_FIRST ? 3'd7 : 3'd0;
   localparam logic [2:0] LAST  = MSB_FIRST ? 3'd0 : 3'd7;

   state_t     state_q, state_d;
   logic [7:0] shadow_q, shadow_d;
   logic [2:0] s_q, s_d;
   logic       y_q, y_d;
   logic [2:0] next_idx;

   assign next_idx = MSB_FIRST ? (s_q - 3'd1) : (s_q + 3'd1);

   always_comb begin
      state_d  = state_q;
      shadow_d = shadow_q;
      s_d      = s_q;
      y_d      = y_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d  = SEND;
               shadow_d = D;
               s_d      = FIRST;
               y_d      = D[FIRST];
            end
         end
         SEND: begin
            if (s_q == LAST) begin
               // start on the final slot chains the next frame with no gap
               if (start) begin
                  shadow_d = D;
                  s_d      = FIRST;
                  y_d      = D[FIRST];
               end else begin
                  state_d = IDLE;
                  s_d     = 3'd0;
                  y_d     = 1'b0;
               end
            end else begin
               s_d = next_idx;
               y_d = shadow_q[next_idx];
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         shadow_q <= 8'h00;
         s_q      <= 3'd0;
         y_q      <= 1'b0;
      end else begin
         state_q  <= state_d;
         shadow_q <= shadow_d;
         s_q      <= s_d;
         y_q      <= y_d;
      end
   end

   assign busy  = (state_q == SEND);
   assign valid = busy;
   assign last  = busy && (s_q == LAST);
   assign Y     = y_q;
   assign S     = s_q;

endmodule

// File: tb/tb_tdm_mux_8x1.sv
// Directed bench for tdm_mux_8x1: LSB-first and MSB-first instances
// share stimulus; each scenario task checks its own expected values.
module tb_tdm_mux_8x1;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] D;
   logic       start;
   logic       y0, v0, l0, b0;
   logic [2:0] s0;
   logic       y1, v1, l1, b1;
   logic [2:0] s1;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   tdm_mux_8x1 #(.MSB_FIRST(1'b0)) dut0 (
      .clk(clk), .rst(rst), .D(D), .start(start),
      .Y(y0), .S(s0), .valid(v0), .last(l0), .busy(b0)
   );

   tdm_mux_8x1 #(.MSB_FIRST(1'b1)) dut1 (
      .clk(clk), .rst(rst), .D(D), .start(start),
      .Y(y1), .S(s1), .valid(v1), .last(l1), .busy(b1)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      logic [6:0] got;
      rst = 1'b1; start = 1'b1; D = 8'hFF;
      tick; tick;
      got = {y0, s0, v0, l0, b0};
      n_chk++;
      if (got !== 7'd0) begin
         n_fail++;
         $display("FAIL reset_lsb got=%b exp=%b", got, 7'd0);
      end
      got = {y1, s1, v1, l1, b1};
      n_chk++;
      if (got !== 7'd0) begin
         n_fail++;
         $display("FAIL reset_msb got=%b exp=%b", got, 7'd0);
      end
      rst = 1'b0; start = 1'b0; D = 8'h00;
      tick;
      n_chk++;
      if ({v0, b0} !== 2'b00) begin
         n_fail++;
         $display("FAIL idle_no_start got=%b exp=00", {v0, b0});
      end
   endtask

   task automatic test_lsb_frame;
      logic [7:0] d;
      logic [5:0] got, exp;
      d = 8'hA5;
      D = d; start = 1'b1;
      tick;
      start = 1'b0; D = 8'h00;
      for (int k = 0; k < 8; k++) begin
         got = {y0, s0, v0, l0};
         exp = {d[k], 3'(k), 1'b1, (k == 7)};
         n_chk++;
         if (got !== exp) begin
            n_fail++;
            $display("FAIL lsb_slot%0d got=%b exp=%b", k, got, exp);
         end
         tick;
      end
      got = {y0, s0, v0, l0};
      n_chk++;
      if (got !== 6'd0 || b0 !== 1'b0) begin
         n_fail++;
         $display("FAIL lsb_end got=%b busy=%b exp=0", got, b0);
      end
   endtask

   task automatic test_msb_frame;
      logic [7:0] d;
      logic [5:0] got, exp;
      d = 8'h01;
      D = d; start = 1'b1;
      tick;
      start = 1'b0;
      for (int k = 0; k < 8; k++) begin
         got = {y1, s1, v1, l1};
         exp = {d[7-k], 3'(7 - k), 1'b1, (k == 7)};
         n_chk++;
         if (got !== exp) begin
            n_fail++;
            $display("FAIL msb_slot%0d got=%b exp=%b", k, got, exp);
         end
         tick;
      end
      n_chk++;
      if ({v1, l1, b1} !== 3'b000) begin
         n_fail++;
         $display("FAIL msb_end got=%b exp=000", {v1, l1, b1});
      end
   endtask

   task automatic test_back_to_back;
      logic [5:0] got, exp;
      D = 8'hFF; start = 1'b1;
      tick;
      for (int k = 0; k < 16; k++) begin
         got = {y0, s0, v0, l0};
         exp = {(k < 8), 3'(k % 8), 1'b1, (k % 8 == 7)};
         n_chk++;
         if (got !== exp) begin
            n_fail++;
            $display("FAIL b2b_cyc%0d got=%b exp=%b", k + 1, got, exp);
         end
         if (k == 7) D = 8'h00;
         if (k == 15) start = 1'b0;
         tick;
      end
      n_chk++;
      if (v0 !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_end valid=%b exp=0", v0);
      end
   endtask

   task automatic test_ignore_start;
      logic [5:0] got, exp;
      D = 8'hFF; start = 1'b1;
      tick;
      start = 1'b0;
      for (int k = 0; k < 8; k++) begin
         got = {y0, s0, v0, l0};
         exp = {1'b1, 3'(k), 1'b1, (k == 7)};
         n_chk++;
         if (got !== exp) begin
            n_fail++;
            $display("FAIL ign_slot%0d got=%b exp=%b", k, got, exp);
         end
         start = (k == 2);
         if (k == 2) D = 8'h00;
         tick;
      end
      start = 1'b0;
      tick;
      n_chk++;
      if ({v0, b0} !== 2'b00) begin
         n_fail++;
         $display("FAIL ign_queued got=%b exp=00", {v0, b0});
      end
   endtask

   task automatic test_mid_reset;
      logic [6:0] got;
      D = 8'hA5; start = 1'b1;
      tick;
      start = 1'b0;
      for (int k = 0; k < 4; k++) tick;
      rst = 1'b1;
      tick;
      rst = 1'b0;
      got = {y0, s0, v0, l0, b0};
      n_chk++;
      if (got !== 7'd0) begin
         n_fail++;
         $display("FAIL midrst got=%b exp=%b", got, 7'd0);
      end
      tick;
      n_chk++;
      if (v0 !== 1'b0) begin
         n_fail++;
         $display("FAIL midrst_resume valid=%b exp=0", v0);
      end
   endtask

   task automatic test_loopback;
      logic [7:0] d;
      logic [7:0] demux;
      d = 8'h3C;
      demux = 8'h00;
      D = d; start = 1'b1;
      tick;
      start = 1'b0; D = 8'h00;
      for (int k = 0; k < 8; k++) begin
         if (v0) demux[s0] = y0;
         n_chk++;
         if (v0 !== 1'b1 || s0 !== 3'(k) || demux[k] !== d[k]) begin
            n_fail++;
            $display("FAIL loop_ch%0d got=%b exp=%b", k, demux[k], d[k]);
         end
         tick;
      end
      n_chk++;
      if (demux !== d) begin
         n_fail++;
         $display("FAIL loop_word got=%h exp=%h", demux, d);
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; D = 8'h00;
      test_reset;
      test_lsb_frame;
      test_msb_frame;
      test_back_to_back;
      test_ignore_start;
      test_mid_reset;
      test_loopback;
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
